// File: rtl/corr_pkg.sv
// Shared constants for the correlator bank scheduler: state codes, default geometry, sweep length.
package corr_pkg;

  localparam int NLAGS_DEF   = 64;
  localparam int AW_DEF      = 6;
  localparam int INTEG_N_DEF = 1024;
  localparam int RD_LAT_DEF  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLR    = 3'd1;
  localparam logic [2:0] ST_WAITS  = 3'd2;
  localparam logic [2:0] ST_MAC    = 3'd3;
  localparam logic [2:0] ST_RDSET  = 3'd4;
  localparam logic [2:0] ST_RDWAIT = 3'd5;
  localparam logic [2:0] ST_RDOUT  = 3'd6;

  // A bank sweep keeps the bank busy for one cycle longer than it has lags.
  function automatic int sweep_len(input int nlags);
    return nlags + 1;
  endfunction

endpackage

// File: rtl/corr_sweep_timer.sv
// Load / count-down / expire timer that measures bank sweeps (clear and MAC).
module corr_sweep_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expire
);

  logic [W-1:0] cnt_r;

  // Loaded on sweep entry; expire marks the last cycle of the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= len;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == W'(1));

endmodule

// File: rtl/corr_bank_sched.sv
// Frame sequencer for one RAM MAC correlator bank: clear sweep, INTEG_N MAC sweeps, lag readout.
// Optional CORR_DROP_CNT_EN adds a saturating drop_cnt port counting samples dropped this frame.
module corr_bank_sched
  import corr_pkg::*;
#(
  parameter int NLAGS   = NLAGS_DEF,
  parameter int AW      = AW_DEF,
  parameter int INTEG_N = INTEG_N_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          smp_valid,
  input  logic [7:0]    smp_data,
  output logic          shift_en,
  output logic          bank_clr,
  output logic          bank_sin,
  output logic [7:0]    bank_a,
  output logic          bank_read,
  output logic [AW-1:0] bank_raddr,
  input  logic [31:0]   bank_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [AW-1:0] out_lag,
  output logic          overrun
`ifdef CORR_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  localparam int SWEEP = sweep_len(NLAGS);
  localparam int TW    = $clog2(SWEEP + 1);
  localparam int CW    = $clog2(INTEG_N + 1);
  localparam int RW    = $clog2(RD_LAT + 1);

  localparam logic [TW-1:0] SWEEP_V   = TW'(SWEEP);
  localparam logic [CW-1:0] LAST_SMP  = CW'(INTEG_N - 1);
  localparam logic [AW-1:0] LAST_LAG  = AW'(NLAGS - 1);
  localparam logic [RW-1:0] RD_WAIT_V = RW'(RD_LAT - 1);

  logic [2:0]    state_r, state_s;
  logic [CW-1:0] smp_cnt_r, smp_cnt_s;
  logic [AW-1:0] lag_r, lag_s;
  logic [RW-1:0] rd_cnt_r, rd_cnt_s;
  logic [7:0]    a_s;
  logic [AW-1:0] raddr_s, olag_s;
  logic [31:0]   odata_s;
  logic          clr_s, sin_s, read_s, valid_s, done_s, ovr_s, busy_s;
  logic          tmr_load_s, tmr_expire_s;

  corr_sweep_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load_s),
    .len    (SWEEP_V),
    .expire (tmr_expire_s)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s    = state_r;
    smp_cnt_s  = smp_cnt_r;
    lag_s      = lag_r;
    rd_cnt_s   = rd_cnt_r;
    a_s        = bank_a;
    raddr_s    = bank_raddr;
    read_s     = bank_read;
    valid_s    = out_valid;
    odata_s    = out_data;
    olag_s     = out_lag;
    ovr_s      = overrun;
    clr_s      = 1'b0;
    sin_s      = 1'b0;
    done_s     = 1'b0;
    tmr_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_CLR;
          clr_s      = 1'b1;
          tmr_load_s = 1'b1;
          ovr_s      = 1'b0;
          smp_cnt_s  = '0;
          lag_s      = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (tmr_expire_s) begin
          state_s = ST_WAITS;
        end else begin
          state_s = ST_CLR;
        end
      end
      ST_WAITS: begin
        if (smp_valid) begin
          state_s    = ST_MAC;
          a_s        = smp_data;
          sin_s      = 1'b1;
          tmr_load_s = 1'b1;
        end else begin
          state_s = ST_WAITS;
        end
      end
      ST_MAC: begin
        // Samples during a sweep, including its final cycle, are lost.
        if (smp_valid) begin
          ovr_s = 1'b1;
        end else begin
          ovr_s = overrun;
        end
        if (tmr_expire_s) begin
          smp_cnt_s = smp_cnt_r + CW'(1);
          if (smp_cnt_r == LAST_SMP) begin
            state_s = ST_RDSET;
            lag_s   = '0;
            raddr_s = '0;
            read_s  = 1'b1;
          end else begin
            state_s = ST_WAITS;
          end
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_RDSET: begin
        state_s  = ST_RDWAIT;
        rd_cnt_s = RD_WAIT_V;
      end
      ST_RDWAIT: begin
        if (rd_cnt_r == '0) begin
          state_s = ST_RDOUT;
          odata_s = bank_rdata;
          olag_s  = lag_r;
          valid_s = 1'b1;
        end else begin
          rd_cnt_s = rd_cnt_r - RW'(1);
        end
      end
      ST_RDOUT: begin
        if (out_ready) begin
          valid_s = 1'b0;
          if (lag_r == LAST_LAG) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
            read_s  = 1'b0;
            lag_s   = '0;
            raddr_s = '0;
          end else begin
            state_s = ST_RDSET;
            lag_s   = lag_r + AW'(1);
            raddr_s = lag_r + AW'(1);
          end
        end else begin
          state_s = ST_RDOUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        read_s  = 1'b0;
        valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      smp_cnt_r  <= '0;
      lag_r      <= '0;
      rd_cnt_r   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      shift_en   <= 1'b0;
      bank_clr   <= 1'b0;
      bank_sin   <= 1'b0;
      bank_a     <= 8'h00;
      bank_read  <= 1'b0;
      bank_raddr <= '0;
      out_valid  <= 1'b0;
      out_data   <= 32'h0000_0000;
      out_lag    <= '0;
      overrun    <= 1'b0;
    end else begin
      state_r    <= state_s;
      smp_cnt_r  <= smp_cnt_s;
      lag_r      <= lag_s;
      rd_cnt_r   <= rd_cnt_s;
      busy       <= busy_s;
      done       <= done_s;
      shift_en   <= sin_s;
      bank_clr   <= clr_s;
      bank_sin   <= sin_s;
      bank_a     <= a_s;
      bank_read  <= read_s;
      bank_raddr <= raddr_s;
      out_valid  <= valid_s;
      out_data   <= odata_s;
      out_lag    <= olag_s;
      overrun    <= ovr_s;
    end
  end

`ifdef CORR_DROP_CNT_EN
  logic drop_s, start_ok_s;
  assign drop_s     = (state_r == ST_MAC) && smp_valid;
  assign start_ok_s = (state_r == ST_IDLE) && start;

  // Saturating per-frame count of dropped samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 16'h0000;
    end else if (start_ok_s) begin
      drop_cnt <= 16'h0000;
    end else if (drop_s && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'h0001;
    end else begin
      drop_cnt <= drop_cnt;
    end
  end
`endif

endmodule
